memory_interface: RTL and testbench

MEMORY_INTERFACE -- requirements
Module: memory_interface

---
 rtl/memory_interface_pkg.sv | 13 +
 rtl/memory_interface_wait_timer.sv | 39 +++
 rtl/memory_interface.sv | 125 ++++++++++++
 tb/tb_memory_interface.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/memory_interface_pkg.sv
// Shared CPU definitions: memory-interface FSM encodings and the default ack timeout.
package memory_interface_pkg;

    localparam int unsigned DefTimeout = 15;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StRdWait = 2'd1,
        StWrWait = 2'd2,
        StDone   = 2'd3
    } mem_state_e;

endpackage

// File: rtl/memory_interface_wait_timer.sv
// Saturating wait-cycle counter; flags the cycle in which the last permitted wait expires.
module wait_timer
    import memory_interface_pkg::*;
#(
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic clear_i,
    input  logic tick_i,
    output logic expire_o
);

    localparam int unsigned CntW = $clog2(TIMEOUT + 1);
    localparam logic [CntW-1:0] MaxCnt = CntW'(TIMEOUT);

    logic [CntW-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (tick_i && (cnt_q != MaxCnt)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    // This tick brings the count to TIMEOUT.
    assign expire_o = tick_i && (cnt_q == MaxCnt - 1'b1);

endmodule

// File: rtl/memory_interface.sv
// CPU memory interface: MAR/MDR registers plus a request/ack handshake FSM with timeout.
module memory_interface
    import memory_interface_pkg::*;
#(
    parameter int unsigned ADDR_W  = 9,
    parameter int unsigned TIMEOUT = DefTimeout
) (
    input  logic              Clock,
    input  logic              Reset,
    input  logic [31:0]       BusMuxOut,
    input  logic              MARin,
    input  logic              MDRin,
    input  logic              Read,
    input  logic              Write,
    output logic [31:0]       MDRdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_ack,
    output logic              Busy,
    output logic              Done,
    output logic              Err
);

    mem_state_e        state_q, state_d;
    logic [ADDR_W-1:0] mar_q, mar_d;
    logic [31:0]       mdr_q, mdr_d;
    logic              err_q, err_d;

    logic idle, waiting, rd_req, wr_req, conflict, expire;

    assign idle     = (state_q == StIdle);
    assign waiting  = (state_q == StRdWait) || (state_q == StWrWait);
    assign rd_req   = MDRin && Read;
    assign wr_req   = Write && !MDRin;
    // Read wins a read/write collision, but the collision is still reported.
    assign conflict = MDRin && Read && Write;

    wait_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_wait_timer (
        .clk_i    (Clock),
        .rst_ni   (Reset),
        .clear_i  (idle && (rd_req || wr_req)),
        .tick_i   (waiting && !mem_ack),
        .expire_o (expire)
    );

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (rd_req) begin
                    state_d = StRdWait;
                end else if (wr_req) begin
                    state_d = StWrWait;
                end
            end
            StRdWait, StWrWait: begin
                if (mem_ack) begin
                    state_d = StDone;
                end else if (expire) begin
                    state_d = StIdle;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        Busy   = (state_q != StIdle);
        mem_rd = (state_q == StRdWait);
        mem_wr = (state_q == StWrWait);
        Done   = (state_q == StDone);
    end

    // MAR/MDR only move in IDLE (bus loads) or on a read ack, so they stay stable per transaction.
    always_comb begin
        mar_d = mar_q;
        mdr_d = mdr_q;
        err_d = 1'b0;
        if (idle) begin
            if (MARin) begin
                mar_d = BusMuxOut[ADDR_W-1:0];
            end
            if (MDRin && !Read) begin
                mdr_d = BusMuxOut;
            end
            err_d = conflict;
        end else if (state_q == StRdWait && mem_ack) begin
            mdr_d = mem_rdata;
        end else if (expire) begin
            err_d = 1'b1;
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            mar_q <= '0;
            mdr_q <= '0;
            err_q <= 1'b0;
        end else begin
            mar_q <= mar_d;
            mdr_q <= mdr_d;
            err_q <= err_d;
        end
    end

    assign MDRdata   = mdr_q;
    assign mem_addr  = mar_q;
    assign mem_wdata = mdr_q;
    assign Err       = err_q;

endmodule

// File: tb/tb_memory_interface.sv
// Bench for memory_interface: vector table for IDLE bus loads, hand sequences for transactions.
module tb_memory_interface;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] BusMuxOut = '0;
    logic        MARin = 1'b0, MDRin = 1'b0, Read = 1'b0, Write = 1'b0;
    logic [31:0] MDRdata, mem_wdata;
    logic [8:0]  mem_addr;
    logic        mem_rd, mem_wr, Busy, Done, Err;
    logic [31:0] mem_rdata = '0;
    logic        mem_ack = 1'b0;

    int n_tests = 0;
    int n_fail  = 0;

    logic [31:0] exp_q[$];

    typedef struct {
        logic        marin, mdrin, read, write;
        logic [31:0] bus;
        logic [31:0] exp_mdr;
        logic [8:0]  exp_addr;
    } vec_t;

    typedef struct {
        int busy, rd, wr, both, done, done_at, err, err_at, bad;
    } res_t;

    memory_interface #(
        .ADDR_W  (9),
        .TIMEOUT (15)
    ) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .BusMuxOut (BusMuxOut),
        .MARin     (MARin),
        .MDRin     (MDRin),
        .Read      (Read),
        .Write     (Write),
        .MDRdata   (MDRdata),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .mem_ack   (mem_ack),
        .Busy      (Busy),
        .Done      (Done),
        .Err       (Err)
    );

    always #5 Clock = ~Clock;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] ctl();
        return {18'd0, mem_addr, mem_rd, mem_wr, Busy, Done, Err};
    endfunction

    task automatic drive(input logic marin, input logic mdrin, input logic read,
                         input logic write, input logic [31:0] bus);
        MARin = marin; MDRin = mdrin; Read = read; Write = write; BusMuxOut = bus;
    endtask

    // Called right after a request is driven at a negedge; observes ncyc following cycles.
    task automatic watch(input int ack_cyc, input logic [31:0] rdata, input logic poke,
                         input logic [8:0] exp_addr, input int ncyc, output res_t r);
        logic [31:0] mdr0;
        mdr0 = MDRdata;
        r = '{default: 0};
        for (int c = 1; c <= ncyc; c++) begin
            @(negedge Clock);
            r.busy += int'(Busy);
            r.rd   += int'(mem_rd);
            r.wr   += int'(mem_wr);
            r.both += int'(mem_rd && mem_wr);
            if (Done) begin
                r.done++;
                if (r.done_at == 0) r.done_at = c;
                if (exp_q.size() > 0) chk("rd_data", MDRdata, exp_q.pop_front());
            end
            if (Err) begin
                r.err++;
                if (r.err_at == 0) r.err_at = c;
            end
            if (Busy && (mem_addr !== exp_addr)) r.bad++;
            if (Busy && !Done && (MDRdata !== mdr0 || mem_wdata !== mdr0)) r.bad++;
            if (poke && Busy && !Done) drive(1'b1, 1'b1, 1'b0, 1'b1, 32'hFFFF_FFFF);
            else drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            mem_ack   = (c == ack_cyc);
            mem_rdata = (c == ack_cyc) ? rdata : 32'h0BAD_0BAD;
        end
    endtask

    initial begin
        vec_t vecs[5];
        res_t r;

        vecs[0] = '{1'b0, 1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'hDEAD_BEEF, 9'h000};
        vecs[1] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h1234_5055, 32'hDEAD_BEEF, 9'h055};
        vecs[2] = '{1'b1, 1'b1, 1'b0, 1'b0, 32'hA5A5_A1FF, 32'hA5A5_A1FF, 9'h1FF};
        vecs[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 32'h7777_7777, 32'hA5A5_A1FF, 9'h1FF};
        vecs[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0200, 32'hA5A5_A1FF, 9'h000};

        #1 Reset = 1'b0;
        #2;
        chk("reset_mdr", MDRdata, 32'h0);
        chk("reset_wdata", mem_wdata, 32'h0);
        chk("reset_ctl", ctl(), 32'h0);
        @(negedge Clock);
        Reset = 1'b1;

        // IDLE bus loads: expected register contents go to the scoreboard at drive time.
        for (int i = 0; i < 5; i++) begin
            drive(vecs[i].marin, vecs[i].mdrin, vecs[i].read, vecs[i].write, vecs[i].bus);
            exp_q.push_back(vecs[i].exp_mdr);
            exp_q.push_back({23'd0, vecs[i].exp_addr});
            @(negedge Clock);
            drive(1'b0, 1'b0, 1'b0, 1'b0, 32'h0);
            chk($sformatf("vec%0d_mdr", i), MDRdata, exp_q.pop_front());
            chk($sformatf("vec%0d_addr", i), {23'd0, mem_addr}, exp_q.pop_front());
            chk($sformatf("vec%0d_ctl", i), {29'd0, mem_rd, Busy, Done}, 32'h0);
        end

        // Read from 0x055, ack in the third wait cycle.
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_0055);
        @(negedge Clock);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        exp_q.push_back(32'h1234_5678);
        watch(3, 32'h1234_5678, 1'b0, 9'h055, 6, r);
        chk("rd_busy_cycles", r.busy, 4);
        chk("rd_strobe_cycles", r.rd, 3);
        chk("rd_done_count", r.done, 1);
        chk("rd_done_at", r.done_at, 4);
        chk("rd_err", r.err, 0);
        chk("rd_stable", r.bad, 0);
        chk("rd_mdr_after", MDRdata, 32'h1234_5678);

        // Write 0xCAFE0001 to 0x1FF, immediate ack.
        drive(1'b0, 1'b1, 1'b0, 1'b0, 32'hCAFE_0001);
        @(negedge Clock);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 32'h0000_01FF);
        @(negedge Clock);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 32'h0);
        watch(1, 32'h0, 1'b0, 9'h1FF, 4, r);
        chk("wr_strobe_cycles", r.wr, 1);
        chk("wr_rd_strobe", r.rd, 0);
        chk("wr_done_at", r.done_at, 2);
        chk("wr_stable", r.bad, 0);

        // MARin together with a write: the access uses the freshly loaded address.
        drive(1'b1, 1'b0, 1'b0, 1'b1, 32'h0000_00AA);
        watch(2, 32'h0, 1'b0, 9'h0AA, 5, r);
        chk("marw_done_at", r.done_at, 3);
        chk("marw_wr_cycles", r.wr, 2);
        chk("marw_stable", r.bad, 0);

        // Timeout: no ack ever.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        watch(0, 32'h0, 1'b0, 9'h0AA, 20, r);
        chk("to_rd_cycles", r.rd, 15);
        chk("to_busy_cycles", r.busy, 15);
        chk("to_err_count", r.err, 1);
        chk("to_err_at", r.err_at, 16);
        chk("to_done", r.done, 0);
        chk("to_mdr_kept", MDRdata, 32'hCAFE_0001);
        chk("to_idle", {31'd0, Busy}, 32'h0);

        // Requests and register loads while busy are ignored.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        exp_q.push_back(32'h600D_F00D);
        watch(3, 32'h600D_F00D, 1'b1, 9'h0AA, 6, r);
        chk("poke_wr", r.wr, 0);
        chk("poke_busy", r.busy, 4);
        chk("poke_stable", r.bad, 0);
        chk("poke_addr", {23'd0, mem_addr}, 32'h0AA);

        // Read, MDRin and Write together: read proceeds, Err one cycle after the request.
        drive(1'b0, 1'b1, 1'b1, 1'b1, 32'h0);
        exp_q.push_back(32'h0000_ABCD);
        watch(2, 32'h0000_ABCD, 1'b0, 9'h0AA, 5, r);
        chk("cf_err_count", r.err, 1);
        chk("cf_err_at", r.err_at, 1);
        chk("cf_wr", r.wr, 0);
        chk("cf_rd", r.rd, 2);
        chk("cf_done_at", r.done_at, 3);
        chk("never_both", r.both, 0);
        chk("sb_empty", exp_q.size(), 0);

        // Reset in RD_WAIT clears everything without a clock edge.
        drive(1'b0, 1'b1, 1'b1, 1'b0, 32'h0);
        watch(0, 32'h0, 1'b0, 9'h0AA, 2, r);
        chk("mid_busy_before", {31'd0, mem_rd}, 32'h1);
        #2 Reset = 1'b0;
        #1;
        chk("mid_reset_mdr", MDRdata, 32'h0);
        chk("mid_reset_wdata", mem_wdata, 32'h0);
        chk("mid_reset_ctl", ctl(), 32'h0);
        @(negedge Clock);
        Reset = 1'b1;
        watch(1, 32'h1111_1111, 1'b0, 9'h000, 4, r);
        chk("post_reset_done", r.done, 0);
        chk("post_reset_err", r.err, 0);
        chk("post_reset_busy", r.busy, 0);
        chk("post_reset_mdr", MDRdata, 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

endmodule
